// File: rtl/dds_sweep_controller.sv
// ---------------------------------------------------------------------------
// dds_sweep_controller
//
// Steps the DDS frequency tuning word from a start word to a stop word. Each
// word is held for a programmable number of clocks. Single, repeating and
// triangle sweeps are supported. In IDLE the last word is held.
//
// Ports:
//   clk        in  1        system clock, rising edge
//   reset      in  1        asynchronous, active-low reset
//   cfg_start  in  W        sweep start word
//   cfg_stop   in  W        sweep stop word
//   cfg_step   in  W        increment per step
//   cfg_dwell  in  DWELL_W  clocks each word is held
//   cfg_mode   in  2        0 single, 1 repeat, 2 triangle, 3 illegal
//   cfg_load   in  1        pulse: latch cfg_* into shadow registers (IDLE only)
//   start      in  1        pulse: begin sweep
//   abort      in  1        pulse: stop sweep, hold current word
//   step_word  out W        tuning word to the phase accumulator
//   word_valid out 1        pulse whenever step_word changes
//   busy       out 1        sweep in progress
//   done       out 1        pulse at normal completion of a single sweep
//   cfg_err    out 1        sticky: shadow configuration invalid
// ---------------------------------------------------------------------------
module dds_sweep_controller #(
    parameter int              W            = 32,
    parameter int              DWELL_W      = 24,
    parameter logic [W-1:0]    DEFAULT_WORD = 32'd171798691
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       cfg_start,
    input  logic [W-1:0]       cfg_stop,
    input  logic [W-1:0]       cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_load,
    input  logic               start,
    input  logic               abort,
    output logic [W-1:0]       step_word,
    output logic               word_valid,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL  = 2'd3;

    // Upward step clamped at lim; the sum is W+1 bits so a carry clamps too.
    function automatic logic [W-1:0] f_step_up(input logic [W-1:0] cur,
                                               input logic [W-1:0] inc,
                                               input logic [W-1:0] lim);
        logic [W:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        if (sum[W] || (sum[W-1:0] > lim)) begin
            return lim;
        end else begin
            return sum[W-1:0];
        end
    endfunction

    // Downward step clamped at lim; a borrow in the W+1 bit difference clamps.
    function automatic logic [W-1:0] f_step_down(input logic [W-1:0] cur,
                                                 input logic [W-1:0] dec,
                                                 input logic [W-1:0] lim);
        logic [W:0] diff;
        diff = {1'b0, cur} - {1'b0, dec};
        if (diff[W] || (diff[W-1:0] < lim)) begin
            return lim;
        end else begin
            return diff[W-1:0];
        end
    endfunction

    // Registers
    state_t             r_state;
    logic [W-1:0]       r_word;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;
    logic [DWELL_W-1:0] r_cnt;
    logic [W-1:0]       r_sh_start;
    logic [W-1:0]       r_sh_stop;
    logic [W-1:0]       r_sh_step;
    logic [DWELL_W-1:0] r_sh_dwell;
    logic [1:0]         r_sh_mode;

    // Combinational next values
    state_t             w_state_nxt;
    logic [W-1:0]       w_word_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_done_nxt;
    logic               w_start_ev;
    logic               w_valid_nxt;
    logic               w_busy_nxt;
    logic               w_start_ok;
    logic               w_load_ok;
    logic               w_cfg_bad;
    logic [W-1:0]       w_up_word;
    logic [W-1:0]       w_dn_word;
    logic [DWELL_W-1:0] w_dwell_rld;

    // Loads are only taken while idle; a simultaneous load suppresses start,
    // and abort always wins over start.
    assign w_load_ok   = cfg_load && (r_state == S_IDLE);
    assign w_start_ok  = start && !abort && !cfg_load && !r_cfg_err && (r_state == S_IDLE);
    assign w_cfg_bad   = (cfg_step == {W{1'b0}}) || (cfg_dwell == {DWELL_W{1'b0}}) ||
                         (cfg_start > cfg_stop) || (cfg_mode == MODE_ILLEGAL);
    assign w_dwell_rld = r_sh_dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
    assign w_up_word   = f_step_up(r_word, r_sh_step, r_sh_stop);
    assign w_dn_word   = f_step_down(r_word, r_sh_step, r_sh_start);

    // Shadow configuration registers and sticky configuration error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh_start <= DEFAULT_WORD;
            r_sh_stop  <= DEFAULT_WORD;
            r_sh_step  <= {{(W-1){1'b0}}, 1'b1};
            r_sh_dwell <= {{(DWELL_W-1){1'b0}}, 1'b1};
            r_sh_mode  <= MODE_SINGLE;
            r_cfg_err  <= 1'b0;
        end else if (w_load_ok) begin
            r_sh_start <= cfg_start;
            r_sh_stop  <= cfg_stop;
            r_sh_step  <= cfg_step;
            r_sh_dwell <= cfg_dwell;
            r_sh_mode  <= cfg_mode;
            r_cfg_err  <= w_cfg_bad;
        end else begin
            r_sh_start <= r_sh_start;
            r_sh_stop  <= r_sh_stop;
            r_sh_step  <= r_sh_step;
            r_sh_dwell <= r_sh_dwell;
            r_sh_mode  <= r_sh_mode;
            r_cfg_err  <= r_cfg_err;
        end
    end

    // State register plus registered datapath and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_word  <= DEFAULT_WORD;
            r_cnt   <= {DWELL_W{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: dwell countdown and step decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_start_ev  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_UP;
                    w_word_nxt  = r_sh_start;
                    w_cnt_nxt   = w_dwell_rld;
                    w_start_ev  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_UP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != {DWELL_W{1'b0}}) begin
                    w_cnt_nxt = r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else begin
                    w_cnt_nxt = w_dwell_rld;
                    if (r_word == r_sh_stop) begin
                        case (r_sh_mode)
                            MODE_SINGLE: begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                            MODE_REPEAT: begin
                                w_word_nxt = r_sh_start;
                            end
                            MODE_TRIANGLE: begin
                                w_state_nxt = S_DOWN;
                                w_word_nxt  = w_dn_word;
                            end
                            default: begin
                                w_state_nxt = S_IDLE;
                            end
                        endcase
                    end else begin
                        w_word_nxt = w_up_word;
                    end
                end
            end
            S_DOWN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != {DWELL_W{1'b0}}) begin
                    w_cnt_nxt = r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else begin
                    w_cnt_nxt = w_dwell_rld;
                    if (r_word == r_sh_start) begin
                        w_state_nxt = S_UP;
                        w_word_nxt  = w_up_word;
                    end else begin
                        w_word_nxt = w_dn_word;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: word_valid fires on sweep start and on any word change.
    always_comb begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        if (w_start_ev) begin
            w_valid_nxt = 1'b1;
        end else if ((r_state != S_IDLE) && (w_word_nxt != r_word)) begin
            w_valid_nxt = 1'b1;
        end else begin
            w_valid_nxt = 1'b0;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign step_word  = r_word;
    assign word_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;

endmodule

// File: doc/dds_sweep_controller.md
# dds_sweep_controller

Synchronous frequency-sweep sequencer driving the 32-bit frequency tuning word of the DDS phase accumulator. Software or front-panel logic loads a start word, stop word, increment and dwell time; on `start` the block steps the tuning word from start to stop, holding each value for a programmable number of clocks. It supports single, repeating and triangle sweeps. It replaces direct button-driven adjustment of the tuning word whenever a sweep is active; in IDLE it holds the last word.

## Interface
Parameters:
- `W`, 32, tuning word width.
- `DWELL_W`, 24, dwell counter width.
- `DEFAULT_WORD`, 171798691, reset tuning word (2 MHz at 50 MHz clock).

Ports:
- `clk`  in  1  system clock, all logic rising-edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `cfg_start`  in  W  sweep start word.
- `cfg_stop`  in  W  sweep stop word.
- `cfg_step`  in  W  increment per step.
- `cfg_dwell`  in  DWELL_W  clocks each word is held.
- `cfg_mode`  in  2  0 single, 1 repeat, 2 triangle, 3 illegal.
- `cfg_load`  in  1  one-cycle pulse, latch cfg_* into shadow registers.
- `start`  in  1  one-cycle pulse, begin sweep.
- `abort`  in  1  one-cycle pulse, stop sweep.
- `step_word`  out  W  tuning word to phase accumulator.
- `word_valid`  out  1  one-cycle pulse whenever `step_word` changes value.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at normal completion of a single sweep.
- `cfg_err`  out  1  sticky, shadow config invalid.

## Operation
- Reset values: `step_word`=DEFAULT_WORD, `word_valid`=0, `busy`=0, `done`=0, `cfg_err`=0, state IDLE.
- Shadow reset values: start=stop=DEFAULT_WORD, step=1, dwell=1, mode=0.
- States: IDLE, UP, DOWN.
- `cfg_load` is accepted in IDLE only and ignored when `busy`. The shadow registers update and `cfg_err` is recomputed.
- `cfg_err`=1 if any of: step==0, dwell==0, start>stop, mode==3. It stays set until the next accepted `cfg_load`.
- `start` is accepted in IDLE with `cfg_err`=0. Otherwise it is ignored; `start` while busy is also ignored.
- On start: `step_word`<=start, `word_valid` pulses, dwell counter loads dwell-1, go to UP.
- Dwell: the counter decrements each clock. At 0 the block takes a step decision.
- UP step:
  - If cur==stop, the end of an up leg is reached: mode 0 -> IDLE, `done` pulse, word holds stop; mode 1 -> word<=start, stay UP; mode 2 -> go to DOWN, compute one down step now.
  - Else word<=min(cur+step, stop). The sum is computed at W+1 bits; a carry counts as exceeding stop, so the word never wraps.
- DOWN step (mode 2 only):
  - If cur==start: go to UP, compute one up step now.
  - Else word<=max(cur-step, start). The difference is computed at W+1 bits; a borrow counts as below start.
- Triangle degenerate case: start==stop means the word is held constant; no `word_valid` after the first, sweep runs until abort.
- `word_valid` pulses only when the new word differs from the old.
- Every step decision reloads the dwell counter with dwell-1.
- `abort` in any state: IDLE next clock, `busy`=0, `step_word` holds its current value, no `done`.
- Simultaneous events:
  - `abort` beats `start`.
  - `cfg_load` and `start` in the same IDLE cycle: the load is applied and `start` is ignored.
  - Reset mid-sweep immediately forces all reset values.

## Timing
- `start` sampled at edge n: `step_word`=start, `word_valid`=1 and `busy`=1 from edge n+1.
- Each word is held exactly `dwell` clocks; the next word appears `dwell` clocks after the previous one.
- Single mode, N distinct words: the final word is held dwell clocks. On the following edge `busy`=0 and `done`=1 for one cycle, i.e. N*dwell clocks after the first word.
- Repeat mode: the wrap to start occurs dwell clocks after stop appears. There is no extra cycle.
- `abort` at edge n: `busy`=0 after edge n.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single sweep, start=100, stop=130, step=10, dwell=3: expect words 100,110,120,130, each 3 clocks, with 4 `word_valid` pulses; `done` pulses 12 clocks after the first word.
- Clamp, start=0, stop=25, step=10, dwell=1: expect 0,10,20,25 then `done`. Triangle mode with the same config: expect 0,10,20,25,15,5,0,10...
- Overflow guard, start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, dwell=2: expect 0xFFFFFFF0 then 0xFFFFFFFF, then `done`, with no wrap to a small value.
- Config errors:
  - step=0 load -> `cfg_err`=1 and `start` produces no `busy`.
  - A valid reload -> `cfg_err`=0.
  - mode=3 -> `cfg_err`=1.
  - `cfg_load` while busy -> shadow registers unchanged.
- Abort/reset: in repeat mode 0..30 step 10 dwell 4, `abort` during word 20 -> `busy`=0 next clock, word stays 20, no `done`. Async `reset` mid-sweep -> `step_word`=171798691 immediately and all flags 0.
- Simultaneous: `start`+`abort` in the same cycle -> stays IDLE. `cfg_load`+`start` in the same cycle -> new config latched and no sweep starts.
